serial_adder: RTL

Parametrised bit-serial adder/subtractor; the sequential successor to the combinational half adder. It adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell and a registered carry. A start/busy/done handshake frames each operation. Results are held in output registers, so downstream logic sees a stable sum, carry and overflow between operations.

---
 rtl/serial_adder.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per clock.
// Result registers update only on completion or reset, so they stay stable between operations.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic             c;

    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] res_next;

    // c is still the carry into the current bit here; on the last bit it is the carry into the MSB.
    always_comb begin
        s        = sh_a[0] ^ sh_b[0] ^ c;
        c_next   = (sh_a[0] & sh_b[0]) | (sh_a[0] & c) | (sh_b[0] & c);
        res_next = res >> 1;
        res_next[WIDTH-1] = s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            c     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= sub ? ~b : b;
                        c     <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    res  <= res_next;
                    c    <= c_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= c_next;
                        ovf   <= c ^ c_next;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
